// File: rtl/mul32_shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier and its cla32 adder.
// MUL_ITER is also meant for the divider block that will reuse this FSM shape.
package mul32_shift_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam int MUL_ITER = 32;
    localparam int CLA_W    = 32;
    localparam int CLA_GRP  = 4;

    // Internal carries c1..c3 of a 4-bit lookahead group; the group carry-out
    // comes from the second-level lookahead instead.
    function automatic logic [2:0] cla4_carries(input logic [3:0] g,
                                                input logic [3:0] p,
                                                input logic       ci);
        logic [2:0] c;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    function automatic logic cla4_group_g(input logic [3:0] g,
                                          input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups joined by a group-level
// generate/propagate chain.
module cla32
    import mul32_shift_add_pkg::*;
(
    input  logic [CLA_W-1:0] a,
    input  logic [CLA_W-1:0] b,
    input  logic             ci,
    output logic [CLA_W-1:0] s,
    output logic             co
);

    localparam int NGRP = CLA_W / CLA_GRP;

    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_p;
    logic [NGRP:0]    grp_c;
    logic [CLA_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        for (int i = 0; i < NGRP; i++) begin
            grp_g[i] = cla4_group_g(g[i*CLA_GRP +: CLA_GRP], p[i*CLA_GRP +: CLA_GRP]);
            grp_p[i] = &p[i*CLA_GRP +: CLA_GRP];
        end
    end

    always_comb begin
        grp_c[0] = ci;
        for (int i = 0; i < NGRP; i++) begin
            grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
        end
    end

    // Bit carries: group boundary carries come from the group chain,
    // the three inner carries from the local lookahead.
    always_comb begin
        c = '0;
        for (int i = 0; i < NGRP; i++) begin
            c[i*CLA_GRP]          = grp_c[i];
            c[i*CLA_GRP + 1 +: 3] = cla4_carries(g[i*CLA_GRP +: CLA_GRP],
                                                 p[i*CLA_GRP +: CLA_GRP],
                                                 grp_c[i]);
        end
        c[CLA_W] = grp_c[NGRP];
    end

    assign s  = p ^ c[CLA_W-1:0];
    assign co = c[CLA_W];

endmodule

// File: rtl/mul32_shift_add.sv
// Sequential unsigned 32x32->64 radix-2 shift-and-add multiplier using one
// cla32 adder; one operation in flight, start/busy/done handshake.
module mul32_shift_add
    import mul32_shift_add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    mul_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   m;
    logic [2*WIDTH-1:0] p;

    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_s;
    logic               add_co;

    assign add_a = p[2*WIDTH-1:WIDTH];
    assign add_b = p[0] ? m : '0;

    cla32 U0_cla32 (
        .a  (add_a),
        .b  (add_b),
        .ci (1'b0),
        .s  (add_s),
        .co (add_co)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            m     <= '0;
            p     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= a;
                        p     <= {{WIDTH{1'b0}}, b};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // 65-bit {co,sum,low} shifted right by one; the carry lands in the MSB
                    p   <= {add_co, add_s, p[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(MUL_ITER - 1)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign product = p;

endmodule

// File: tb/tb_mul32_shift_add.sv
// Directed and random checks for mul32_shift_add: latency, handshake,
// ignored starts, async reset abort and product values.
module tb_mul32_shift_add;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul32_shift_add #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered 1 time unit after an edge with the DUT idle; start is sampled at
    // the next edge (E0). Returns 1 time unit after E33. pulse1/pulse2 name
    // edges at which a stray start with a=b=9 is presented.
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                          input int pulse1, input int pulse2,
                          input logic [63:0] exp, input string tag);
        int done_edge = 0;
        int done_cnt  = 0;
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a     = ~op_a;
        b     = ~op_b;
        chk({tag, " busy_after_e0"}, {63'b0, busy}, 64'd1);
        chk({tag, " done_after_e0"}, {63'b0, done}, 64'd0);
        for (int k = 1; k <= 33; k++) begin
            if (k == pulse1 || k == pulse2) begin
                start = 1'b1;
                a     = 32'd9;
                b     = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                if (done_edge == 0) done_edge = k;
            end
            if (k == 32) chk({tag, " product"}, product, exp);
        end
        start = 1'b0;
        chk({tag, " done_edge"}, 64'(done_edge), 64'd32);
        chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
        chk({tag, " busy_after_e33"}, {63'b0, busy}, 64'd0);
        chk({tag, " product_held"}, product, exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] wa;
        logic [63:0] wb;

        #2;
        chk("reset busy", {63'b0, busy}, 64'd0);
        chk("reset done", {63'b0, done}, 64'd0);
        chk("reset product", product, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'd3, 32'd5, 0, 0, 64'h0F, "t1");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 64'hFFFF_FFFE_0000_0001, "t2");
        run_op(32'h1234_5678, 32'd0, 0, 0, 64'd0, "t3a");
        run_op(32'd0, 32'hDEAD_BEEF, 0, 0, 64'd0, "t3b");
        run_op(32'd7, 32'd6, 10, 33, 64'd42, "t4a");
        run_op(32'd9, 32'd9, 0, 0, 64'd81, "t4b");
        run_op(32'h8000_0000, 32'd2, 0, 0, 64'h1_0000_0000, "edge_msb");
        run_op(32'hFFFF_FFFF, 32'd1, 0, 0, 64'h0000_0000_FFFF_FFFF, "edge_one");

        // Abort mid-RUN with an asynchronous reset between edges
        a     = 32'd100;
        b     = 32'd100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t5 busy_async", {63'b0, busy}, 64'd0);
        chk("t5 done_async", {63'b0, done}, 64'd0);
        chk("t5 product_async", product, 64'd0);
        @(posedge clk); #1;
        chk("t5 busy_held", {63'b0, busy}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'd2, 32'd2, 0, 0, 64'd4, "t5");

        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            wa = {32'b0, ra};
            wb = {32'b0, rb};
            run_op(ra, rb, 0, 0, wa * wb, "t6");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
